// File: rtl/uart_pkg.sv
// Shared UART definitions: register addresses, CON bit layout and the serial frame
// state encoding used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_INT_EN = 0;
  localparam int CON_RX_INT_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, start-bit glitch rejection, mid-bit sampling.
// Byte is valid with a one-cycle rx_strobe at the stop-bit centre; no backpressure, framing errors drop the byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] rx_byte,
  output logic       rx_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  ser_state_t    state, state_n;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          din_s, bit_tick, half_tick;

  assign din_s     = sync[1];
  assign bit_tick  = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign rx_byte   = shreg;

  // Idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], din};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (!din_s) state_n = ST_START;
      ST_START: if (half_tick) state_n = din_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_tick && bit_idx == 3'd7) state_n = ST_STOP;
      ST_STOP:  if (bit_tick) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_strobe = (state == ST_STOP) && bit_tick && din_s;
  end

  // The half-bit wait in START aligns every later full-bit tick to a bit centre.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        ST_START: cnt <= half_tick ? '0 : cnt + 1'b1;
        ST_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {din_s, shreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: cnt <= bit_tick ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART (TXD/RXD/CON), 8N1 transmitter and registered level interrupt.
// rdata is combinational (0 cycles); no backpressure: TXD writes while the transmitter is busy are dropped.
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        din,
  output logic        dout,
  output logic        irqout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  ser_state_t    tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic          tx_level, tx_tick, tx_start, tx_finish, tx_busy;
  logic [7:0]    txd_reg, rxd_reg, rx_byte;
  logic          rx_strobe;
  logic          tx_int_en, rx_int_en, tx_done, rx_valid, overrun;
  logic          sel_txd, sel_rxd, sel_con, con_rd, rxd_rd;
  logic [31:0]   con_val;
  logic          unused_wdata;

  assign sel_txd      = (addr == UART_TXD_ADDR);
  assign sel_rxd      = (addr == UART_RXD_ADDR);
  assign sel_con      = (addr == UART_CON_ADDR);
  assign con_rd       = rd && sel_con;
  assign rxd_rd       = rd && sel_rxd;
  assign tx_busy      = (tx_state != ST_IDLE);
  assign tx_tick      = (tx_cnt == BIT_LAST);
  assign tx_start     = wr && sel_txd && !tx_busy;
  assign tx_finish    = (tx_state == ST_STOP) && tx_tick;
  assign unused_wdata = ^wdata[31:8];

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      dout     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      dout     <= tx_level;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        if (tx_start) tx_state_n = ST_START;
      end
      ST_START: begin
        if (tx_tick) begin
          tx_state_n = ST_DATA;
          tx_cnt_n   = '0;
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) tx_state_n = ST_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          tx_state_n = ST_IDLE;
          tx_cnt_n   = '0;
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so dout is a clean flop output.
  always_comb begin
    tx_level = 1'b1;
    case (tx_state_n)
      ST_START: tx_level = 1'b0;
      ST_DATA:  tx_level = txd_reg[tx_bit_n];
      default:  tx_level = 1'b1;
    endcase
  end

  always_comb begin
    con_val                = '0;
    con_val[CON_TX_INT_EN] = tx_int_en;
    con_val[CON_RX_INT_EN] = rx_int_en;
    con_val[CON_TX_DONE]   = tx_done;
    con_val[CON_RX_VALID]  = rx_valid;
    con_val[CON_TX_BUSY]   = tx_busy;
    con_val[CON_OVERRUN]   = overrun;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'd0, txd_reg};
      else if (sel_rxd) rdata = {24'd0, rxd_reg};
      else if (sel_con) rdata = con_val;
    end
  end

  // Event sets take priority over read-side clears landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txd_reg   <= '0;
      rxd_reg   <= '0;
      tx_int_en <= 1'b0;
      rx_int_en <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      irqout    <= 1'b0;
    end else begin
      if (tx_start) txd_reg <= wdata[7:0];
      if (wr && sel_con) begin
        tx_int_en <= wdata[CON_TX_INT_EN];
        rx_int_en <= wdata[CON_RX_INT_EN];
      end
      if (tx_finish)   tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;
      if (rx_strobe) begin
        rxd_reg  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_strobe && rx_valid) overrun <= 1'b1;
      else if (con_rd)           overrun <= 1'b0;
      irqout <= (tx_int_en & tx_done) | (rx_int_en & rx_valid);
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Scenario bench for uart_peripheral at 16 clocks per bit; a line monitor decodes dout
// frames into a queue that each scenario compares against the bytes it wrote.
module tb_uart_peripheral;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int CLK_T = 10;

  logic        clk, reset, rd, wr, din, dout, irqout;
  logic [31:0] addr, wdata, rdata;

  int n_chk = 0;
  int n_pass = 0;
  logic       mon_en = 1'b0;
  logic [8:0] mon_f;
  logic [8:0] tx_exp[$];
  logic [8:0] tx_got[$];
  time        tx_t[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_last;

  uart_peripheral #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .din(din), .dout(dout), .irqout(irqout)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_T/2) clk = ~clk;
  end

  // Line monitor: samples each frame at bit centres, pushes {stop, data}.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && dout === 1'b0) begin
        tx_t.push_back($time);
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (CPB) @(negedge clk);
          mon_f[i] = dout;
        end
        tx_got.push_back(mon_f);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0; addr = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); din = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); din = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int errs;
    mon_en = 1'b0; reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; din = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (dout !== 1'b1) $display("FAIL reset_dout: got %b, expected 1", dout); else n_pass++;
    n_chk++; if (irqout !== 1'b0) $display("FAIL reset_irq: got %b, expected 0", irqout); else n_pass++;
    @(negedge clk); reset = 1'b1;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_con: got %h, expected 0", d); else n_pass++;
    bus_read(UART_RXD_ADDR, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_rxd: got %h, expected 0", d); else n_pass++;
    bus_write(UART_TXD_ADDR, 32'hA5);
    repeat (4) @(negedge clk);
    n_chk++; if (dout !== 1'b0) $display("FAIL midtx_start: got %b, expected 0", dout); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (dout !== 1'b1) $display("FAIL midtx_async_dout: got %b, expected 1", dout); else n_pass++;
    n_chk++; if (irqout !== 1'b0) $display("FAIL midtx_irq: got %b, expected 0", irqout); else n_pass++;
    rd = 1'b1; addr = UART_CON_ADDR;
    #1;
    n_chk++; if (rdata !== 32'h0) $display("FAIL midtx_con: got %h, expected 0", rdata); else n_pass++;
    rd = 1'b0; addr = '0;
    @(negedge clk); reset = 1'b1;
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (dout !== 1'b1) errs++;
    end
    n_chk++; if (errs != 0) $display("FAIL post_reset_idle: got %0d low cycles, expected 0", errs); else n_pass++;
    bus_read(UART_TXD_ADDR, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_txd: got %h, expected 0", d); else n_pass++;
  endtask

  task automatic test_tx();
    logic [31:0] d;
    logic [7:0]  b;
    logic [8:0]  e, g;
    logic        lvl;
    int          errs;
    mon_en = 1'b1;
    b = 8'h55;
    bus_write(UART_CON_ADDR, 32'h1);
    tx_exp.push_back({1'b1, b});
    bus_write(UART_TXD_ADDR, {24'd0, b});
    errs = 0;
    d = '0;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      lvl = (k < 16) ? 1'b0 : (k >= 144) ? 1'b1 : b[(k - 16) / 16];
      if (dout !== lvl) errs++;
      if (k == 159) begin
        rd = 1'b1; addr = UART_CON_ADDR;
        #1 d = rdata;
      end
    end
    @(negedge clk); rd = 1'b0; addr = '0;
    n_chk++; if (errs != 0) $display("FAIL tx_wave: got %0d bad cycles, expected 0", errs); else n_pass++;
    n_chk++; if (d !== 32'h11) $display("FAIL tx_con_last_cycle: got %h, expected 00000011", d); else n_pass++;
    n_chk++; if (irqout !== 1'b0) $display("FAIL tx_irq_early: got %b, expected 0", irqout); else n_pass++;
    @(negedge clk);
    n_chk++; if (irqout !== 1'b1) $display("FAIL tx_irq_rise: got %b, expected 1", irqout); else n_pass++;
    n_chk++;
    if (tx_got.size() == 0 || tx_exp.size() == 0) $display("FAIL tx_frame: got %0d frames, expected 1", tx_got.size());
    else begin
      e = tx_exp.pop_front(); g = tx_got.pop_front();
      if (g !== e) $display("FAIL tx_frame: got %h, expected %h", g, e); else n_pass++;
    end
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h05) $display("FAIL tx_con_done: got %h, expected 00000005", d); else n_pass++;
    @(negedge clk);
    n_chk++; if (irqout !== 1'b0) $display("FAIL tx_irq_drop: got %b, expected 0", irqout); else n_pass++;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h01) $display("FAIL tx_con_cleared: got %h, expected 00000001", d); else n_pass++;
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic [7:0]  e;
    int n;
    bus_write(UART_CON_ADDR, 32'h2);
    rx_exp.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    n = 0;
    while (irqout !== 1'b1 && n < 64) begin
      @(negedge clk); n++;
    end
    n_chk++; if (irqout !== 1'b1) $display("FAIL rx_irq: got %b, expected 1", irqout); else n_pass++;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h0A) $display("FAIL rx_con_valid: got %h, expected 0000000a", d); else n_pass++;
    bus_read(UART_RXD_ADDR, d);
    e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
    n_chk++; if (d !== {24'd0, e}) $display("FAIL rx_data: got %h, expected %h", d, {24'd0, e}); else n_pass++;
    rx_last = e;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h02) $display("FAIL rx_con_cleared: got %h, expected 00000002", d); else n_pass++;
    n_chk++; if (irqout !== 1'b0) $display("FAIL rx_irq_drop: got %b, expected 0", irqout); else n_pass++;
  endtask

  task automatic test_tx_busy_ignore();
    logic [31:0] d;
    logic [8:0]  e, g;
    int n;
    bus_write(UART_CON_ADDR, 32'h0);
    tx_exp.push_back({1'b1, 8'h11});
    bus_write(UART_TXD_ADDR, 32'h11);
    repeat (40) @(negedge clk);
    bus_write(UART_TXD_ADDR, 32'h22);
    bus_read(UART_TXD_ADDR, d);
    n_chk++; if (d !== 32'h11) $display("FAIL busy_txd_read: got %h, expected 00000011", d); else n_pass++;
    n = 0;
    while (tx_got.size() == 0 && n < 300) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (tx_got.size() == 0 || tx_exp.size() == 0) $display("FAIL busy_frame: got %0d frames, expected 1", tx_got.size());
    else begin
      e = tx_exp.pop_front(); g = tx_got.pop_front();
      if (g !== e) $display("FAIL busy_frame: got %h, expected %h", g, e); else n_pass++;
    end
    repeat (200) @(negedge clk);
    n_chk++; if (tx_got.size() != 0) $display("FAIL busy_extra_frame: got %0d frames, expected 0", tx_got.size()); else n_pass++;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h04) $display("FAIL busy_con_done: got %h, expected 00000004", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [8:0]  e, g;
    logic        busy;
    time         gap;
    int n;
    tx_t.delete();
    tx_exp.push_back({1'b1, 8'h3C});
    bus_write(UART_TXD_ADDR, 32'h3C);
    n = 0; busy = 1'b1;
    while (busy && n < 400) begin
      @(negedge clk); rd = 1'b1; addr = UART_CON_ADDR;
      #1 busy = rdata[CON_TX_BUSY];
      n++;
    end
    rd = 1'b0; wr = 1'b1; addr = UART_TXD_ADDR; wdata = 32'hC3;
    tx_exp.push_back({1'b1, 8'hC3});
    @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle_seen: got %b, expected 0", busy); else n_pass++;
    n = 0;
    while (tx_got.size() < 2 && n < 400) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (tx_got.size() == 0 || tx_exp.size() == 0) $display("FAIL b2b_frame%0d: got no frame, expected one", i);
      else begin
        e = tx_exp.pop_front(); g = tx_got.pop_front();
        if (g !== e) $display("FAIL b2b_frame%0d: got %h, expected %h", i, g, e); else n_pass++;
      end
    end
    gap = (tx_t.size() >= 2) ? tx_t[1] - tx_t[0] : 0;
    n_chk++; if (gap != 161 * CLK_T) $display("FAIL b2b_gap: got %0t, expected %0d", gap, 161 * CLK_T); else n_pass++;
    repeat (20) @(negedge clk);
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h04) $display("FAIL b2b_con_done: got %h, expected 00000004", d); else n_pass++;
  endtask

  task automatic test_glitch_framing();
    logic [31:0] d;
    bus_write(UART_CON_ADDR, 32'h2);
    @(negedge clk); din = 1'b0;
    repeat (4) @(negedge clk);
    din = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h02) $display("FAIL glitch_con: got %h, expected 00000002", d); else n_pass++;
    send_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clk);
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h02) $display("FAIL framing_con: got %h, expected 00000002", d); else n_pass++;
    n_chk++; if (irqout !== 1'b0) $display("FAIL framing_irq: got %b, expected 0", irqout); else n_pass++;
    bus_read(UART_RXD_ADDR, d);
    n_chk++; if (d !== {24'd0, rx_last}) $display("FAIL framing_rxd: got %h, expected %h", d, {24'd0, rx_last}); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(UART_CON_ADDR, 32'h0);
    rx_exp.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    rx_exp.push_back(8'h02);
    send_frame(8'h02, 1'b1);
    repeat (10) @(negedge clk);
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h28) $display("FAIL ovr_con_set: got %h, expected 00000028", d); else n_pass++;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h08) $display("FAIL ovr_con_clear: got %h, expected 00000008", d); else n_pass++;
    bus_read(UART_RXD_ADDR, d);
    e = (rx_exp.size() != 0) ? rx_exp[$] : 8'h00;
    rx_exp.delete();
    n_chk++; if (d !== {24'd0, e}) $display("FAIL ovr_rxd: got %h, expected %h", d, {24'd0, e}); else n_pass++;
    bus_read(UART_CON_ADDR, d);
    n_chk++; if (d !== 32'h00) $display("FAIL ovr_con_final: got %h, expected 00000000", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_tx_busy_ignore();
    test_back_to_back();
    test_glitch_framing();
    test_overrun();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_peripheral.md
# uart_peripheral

Memory-mapped UART responder on the CPU data bus. It decodes the CPU's `rd`/`wr`/`addr`/`wdata` strobes for three UART registers and returns read data combinationally on `rdata` within the same cycle. It serializes transmit bytes onto `dout` and deserializes `din` into a receive register. It raises `irqout` when an enabled transmit-done or receive-valid event is pending; this is the same-cycle bus responder the single-cycle core expects.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 4.
- `clk` in 1: system clock. All registers update on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd` in 1: bus read strobe.
- `wr` in 1: bus write strobe.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data. Combinational. Zero when `rd`=0 or the address does not match a register.
- `din` in 1: serial receive line, asynchronous to `clk`.
- `dout` out 1: serial transmit line, registered.
- `irqout` out 1: interrupt request, level.

## Operation
Register map (full 32-bit address match):
- 0x40000018 TXD
  - Write: if TX idle, latch `wdata[7:0]` and start a frame. If TX busy, the write is ignored.
  - Read: last accepted byte, zero-extended.
- 0x4000001C RXD
  - Read: last received byte, zero-extended.
  - A read clears `rx_valid` at the clock edge.
- 0x40000020 CON
  - bit0 `tx_int_en` (RW)
  - bit1 `rx_int_en` (RW)
  - bit2 `tx_done` (RO; cleared by CON read)
  - bit3 `rx_valid` (RO)
  - bit4 `tx_busy` (RO)
  - bit5 `overrun` (RO; cleared by CON read)
  - Writes affect bits 1:0 only.
- `irqout` = (`tx_int_en` & `tx_done`) | (`rx_int_en` & `rx_valid`), registered.

TX state machine:
- States: IDLE → START → DATA → STOP → IDLE.
- Each state lasts `CLKS_PER_BIT` cycles. DATA covers 8 bits, LSB first.
- `dout` levels: 1 in IDLE, 0 in START, data bits in DATA, 1 in STOP.
- `tx_busy` = state ≠ IDLE.

RX state machine:
- States: IDLE → START → DATA → STOP → IDLE.
- `din` passes through a two-flop synchronizer; both flops reset to 1.
- In IDLE, a synchronized 0 enters START.
- START checks the line at `CLKS_PER_BIT/2`. If the line is 1, treat it as a glitch and return to IDLE.
- DATA samples 8 bits, each `CLKS_PER_BIT` apart, at bit centres, LSB first.
- STOP samples once:
  - 1: write RXD and set `rx_valid`. If `rx_valid` was already set, also set `overrun`.
  - 0: framing error. Discard the byte, leave the flags unchanged, return to IDLE.

Simultaneous events:
- Byte completes in the same cycle as an RXD read: new data is stored and `rx_valid` stays 1.
- Frame finishes in the same cycle as a CON read: `tx_done` ends at 1 (set wins).
- Same rule for `overrun`: a set in the same cycle as a CON read wins.
- `rd` and `wr` both high: the write takes effect. Read data reflects pre-edge state.

## Timing
- Reset values: `dout`=1, `irqout`=0, TXD/RXD/CON=0, both state machines in IDLE, bit counters and baud counters 0.
- Reset mid-frame:
  - `dout` returns to 1 asynchronously.
  - A partially received byte is dropped.
- Read latency: 0 cycles (combinational `rdata`). Side-effects (flag clears) apply at the next edge.
- TX frame timing:
  - The accepting TXD write edge is T0.
  - `dout` falls in the cycle after T0.
  - The frame lasts exactly 10·`CLKS_PER_BIT` cycles.
  - `tx_done` is set, and TX returns to IDLE, at the edge that ends STOP.
  - A TXD write accepted in that next cycle starts back-to-back with no extra idle bit.
- RX timing:
  - `rx_valid` rises 2 cycles (synchronizer) plus ~9.5·`CLKS_PER_BIT` after the `din` falling edge.
  - Tolerance: ±4% baud mismatch.
- `irqout` follows the flags with 1 cycle of delay.

## Structure
Shared package `uart_pkg`:
- Register address constants (`UART_TXD_ADDR`, `UART_RXD_ADDR`, `UART_CON_ADDR`).
- CON bit-index constants.
- The 2-bit serial state enum (IDLE/START/DATA/STOP), shared by TX and RX.

Sub-modules:
- One sub-module, `uart_rx`: synchronizer, RX state machine, baud counter. Outputs a byte plus a 1-cycle `rx_strobe`.
- TX state machine, register file, bus decode and IRQ logic live in `uart_peripheral`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Reset low mid-TX → `dout`=1 immediately, CON reads 0x00, `irqout`=0. After reset release, `dout` stays 1.
- Write TXD=0x55, CON=0x01:
  - `dout` = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
  - `tx_done` set 160 cycles after the write edge.
  - `irqout`=1 one cycle later.
  - CON read returns 0x05 and clears `tx_done`; `irqout` drops.
- Drive frame 0xA3 on `din` (CON=0x02):
  - `rx_valid` and `irqout` rise.
  - RXD read returns 0x000000A3.
  - After that edge, CON reads 0x02 and `irqout`=0.
- Write TXD=0x11, then write TXD=0x22 during the frame → only 0x11 is serialized, and a TXD read returns 0x11.
- Drive `din` low for 4 cycles only → no state change, `rx_valid` stays 0.
  - Next, send a frame with stop bit 0 → byte discarded, flags unchanged.
- Receive 0x01, then 0x02 without reading → RXD=0x02, CON bit5=1. A CON read clears bit5.
